// File: rtl/eb_skp_scheduler.sv
// -----------------------------------------------------------------------------
// eb_skp_scheduler
//
// Read-side controller for the RX elastic buffer. It lives in the local (read)
// clock domain, between the buffer storage read port and the 8b/10b decoder.
// It pops symbols from the buffer head and forwards them downstream with one
// cycle of latency. Inside a SKP ordered set (COM followed by SKPs) it may
// delete one SKP or insert one SKP, which pulls the buffer occupancy back
// toward the target band of the selected mode. It makes at most one adjustment
// per ordered set.
//
// Ports:
//   i_read_clk        sole clock
//   i_rst             synchronous, active-high reset
//   i_buffer_mode     0 = nominal half-full, 1 = nominal empty (sampled every cycle)
//   i_fill_level      buffer occupancy 0..BUFFER_DEPTH, before this cycle's read
//   i_head_valid      buffer head entry is valid
//   i_head_data       symbol at the buffer head
//   o_rd_en           combinational: pop the head this cycle
//   o_data_out        registered symbol to the decoder
//   o_data_out_valid  registered: o_data_out is valid
//   o_skp_added       registered one-cycle pulse: SKP inserted
//   o_skp_removed     registered one-cycle pulse: SKP deleted
//   o_underflow       registered: a symbol was needed but the buffer was empty
//   o_overflow        registered: fill level reached BUFFER_DEPTH
// -----------------------------------------------------------------------------
module eb_skp_scheduler #(
    parameter int DATA_WIDTH    = 10,
    parameter int BUFFER_DEPTH  = 16,
    parameter int HIGH_WM_HALF  = 12,
    parameter int LOW_WM_HALF   = 4,
    parameter int HIGH_WM_EMPTY = 4,
    parameter int LOW_WM_EMPTY  = 1,
    localparam int ADDR_W       = $clog2(BUFFER_DEPTH)
) (
    input  logic                  i_read_clk,
    input  logic                  i_rst,
    input  logic                  i_buffer_mode,
    input  logic [ADDR_W:0]       i_fill_level,
    input  logic                  i_head_valid,
    input  logic [DATA_WIDTH-1:0] i_head_data,
    output logic                  o_rd_en,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_out_valid,
    output logic                  o_skp_added,
    output logic                  o_skp_removed,
    output logic                  o_underflow,
    output logic                  o_overflow
);

    localparam int FILL_W = ADDR_W + 1;

    // Both running-disparity encodings of the K28.5 (COM) and K28.0 (SKP) codes.
    localparam logic [9:0] COM_NEG = 10'b0011111010;
    localparam logic [9:0] COM_POS = 10'b1100000101;
    localparam logic [9:0] SKP_NEG = 10'b0011110100;
    localparam logic [9:0] SKP_POS = 10'b1100001011;

    localparam logic [FILL_W-1:0] HI_HALF  = FILL_W'(HIGH_WM_HALF);
    localparam logic [FILL_W-1:0] LO_HALF  = FILL_W'(LOW_WM_HALF);
    localparam logic [FILL_W-1:0] HI_EMPTY = FILL_W'(HIGH_WM_EMPTY);
    localparam logic [FILL_W-1:0] LO_EMPTY = FILL_W'(LOW_WM_EMPTY);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(BUFFER_DEPTH);

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        COM_SEEN = 2'd1,
        SKP_SEEN = 2'd2,  // one SKP of the set already forwarded: adjustment legal
        SKP_DONE = 2'd3   // adjustment made: wait for the next COM
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_last_skp;

    logic                  w_is_com;
    logic                  w_is_skp;
    logic [FILL_W-1:0]     w_hi;
    logic [FILL_W-1:0]     w_lo;
    logic                  w_insert;
    logic                  w_remove;
    state_t                w_default_next;

    // Symbol classification on the 10b code group at the head.
    assign w_is_com = (i_head_data[9:0] == COM_NEG) || (i_head_data[9:0] == COM_POS);
    assign w_is_skp = (i_head_data[9:0] == SKP_NEG) || (i_head_data[9:0] == SKP_POS);

    // Mode switches the thresholds within the same cycle's compare.
    assign w_hi = i_buffer_mode ? HI_EMPTY : HI_HALF;
    assign w_lo = i_buffer_mode ? LO_EMPTY : LO_HALF;

    // Insertion is checked first and does not need a head symbol: it fills
    // the output slot from r_last_skp, so it also covers an empty buffer.
    assign w_insert = !i_rst && (r_state == SKP_SEEN) && (i_fill_level < w_lo);

    // Removal only ever targets a SKP that follows an already-forwarded SKP.
    assign w_remove = !i_rst && (r_state == SKP_SEEN) && !w_insert &&
                      i_head_valid && w_is_skp && (i_fill_level > w_hi);

    // The head is popped whenever it is forwarded or deleted; only an
    // insertion (or reset) leaves a valid head in place.
    assign o_rd_en = !i_rst && i_head_valid && !w_insert;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_default_next = PASS;
        if (w_is_com) begin
            w_default_next = COM_SEEN;
        end else if (w_is_skp && (r_state != PASS)) begin
            // From COM_SEEN a SKP opens the window; in SKP_SEEN/SKP_DONE it
            // keeps the state. In PASS a lone SKP carries no meaning.
            w_default_next = (r_state == SKP_DONE) ? SKP_DONE : SKP_SEEN;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_insert || w_remove) begin
            w_next_state = SKP_DONE;
        end else if (i_head_valid) begin
            w_next_state = w_default_next;
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_read_clk) begin
        if (i_rst) begin
            r_state          <= PASS;
            r_last_skp       <= DATA_WIDTH'(SKP_NEG);
            o_data_out       <= '0;
            o_data_out_valid <= 1'b0;
            o_skp_added      <= 1'b0;
            o_skp_removed    <= 1'b0;
            o_underflow      <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            o_overflow    <= (i_fill_level == FULL);
            o_skp_added   <= w_insert;
            o_skp_removed <= w_remove;

            if (w_insert) begin
                // Reusing the last forwarded SKP encoding keeps running
                // disparity consistent, since SKP is disparity-neutral.
                o_data_out       <= r_last_skp;
                o_data_out_valid <= 1'b1;
                o_underflow      <= 1'b0;
            end else if (w_remove) begin
                o_data_out_valid <= 1'b0;
                o_underflow      <= 1'b0;
            end else if (i_head_valid) begin
                o_data_out       <= i_head_data;
                o_data_out_valid <= 1'b1;
                o_underflow      <= 1'b0;
                if (w_is_skp) begin
                    r_last_skp <= i_head_data;
                end
            end else begin
                o_data_out_valid <= 1'b0;
                o_underflow      <= 1'b1;
            end
        end
    end

endmodule
